// File: rtl/phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : phoenix_vc_buffer
//  Description : Multi-VC input buffer for a Phoenix-style NoC router port.
//                One circular FIFO per virtual channel, per-VC credits, and a
//                shared IDLE/REQ/SEND controller that picks a VC round-robin,
//                requests routing for its header and streams one whole packet
//                (header, size flit, payload) before releasing the port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock     in   1         single clock
//    reset     in   1         synchronous, active-low reset
//    rx        in   1         incoming flit valid
//    lane_rx   in   NUM_VC    one-hot VC select of the incoming flit
//    data_in   in   TAM_FLIT  incoming flit
//    credit_o  out  NUM_VC    per-VC credit to upstream
//    h         out  1         routing request for the selected VC header
//    ack_h     in   1         routing granted
//    data_av   out  1         flit available on data
//    data_ack  in   1         downstream consumed the flit on data
//    data      out  TAM_FLIT  head flit of the selected VC
//    vc_sel    out  VW        selected VC index
//    sender    out  1         high while streaming a packet
//    overflow  out  1         pulse while an incoming flit is being dropped
// ============================================================================
module phoenix_vc_buffer #(
    parameter int TAM_FLIT   = 16,
    parameter int TAM_BUFFER = 8,
    parameter int NUM_VC     = 2,
    localparam int VW        = $clog2(NUM_VC)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [NUM_VC-1:0]   lane_rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic [NUM_VC-1:0]   credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    input  logic                data_ack,
    output logic [TAM_FLIT-1:0] data,
    output logic [VW-1:0]       vc_sel,
    output logic                sender,
    output logic                overflow
);

    localparam int PW  = $clog2(TAM_BUFFER);
    localparam int CW  = PW + 1;
    localparam int VW1 = VW + 1;

    localparam logic [CW-1:0] C_FULL = CW'(TAM_BUFFER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    // Flit position within the packet: 0 = header, 1 = size, 2 = payload
    localparam logic [1:0] F_HDR  = 2'd0;
    localparam logic [1:0] F_SIZE = 2'd1;
    localparam logic [1:0] F_PAY  = 2'd2;

    logic [TAM_FLIT-1:0] mem_q    [NUM_VC][TAM_BUFFER];
    logic [PW-1:0]       rd_ptr_q [NUM_VC];
    logic [PW-1:0]       wr_ptr_q [NUM_VC];
    logic [CW-1:0]       count_q  [NUM_VC];

    logic [NUM_VC-1:0]   push;
    logic [NUM_VC-1:0]   pull;
    logic [NUM_VC-1:0]   full;
    logic [NUM_VC-1:0]   nonempty;
    logic                lane_ok;
    logic                drop;

    logic [1:0]          state_q, state_d;
    logic [VW-1:0]       vc_sel_q, vc_sel_d;
    logic [VW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]          fidx_q, fidx_d;
    logic [TAM_FLIT-1:0] rem_q, rem_d;

    logic [VW-1:0]       vc_next;
    logic [VW:0]         cand_sum;
    logic                found;
    logic [TAM_FLIT-1:0] head;
    logic                pull_sel;
    logic                pkt_end;

    // ------------------------------------------------------------------
    // Per-VC push/pull/credit decode
    // ------------------------------------------------------------------
    assign lane_ok = (lane_rx != '0) && ((lane_rx & (lane_rx - NUM_VC'(1))) == '0);

    always_comb begin
        drop = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]     = (count_q[v] == C_FULL);
            nonempty[v] = (count_q[v] != '0);
            pull[v]     = (state_q == S_SEND) && data_ack && nonempty[v] &&
                          (vc_sel_q == VW'(v));
            // A full VC still accepts a flit when its head leaves this cycle.
            push[v]     = rx && lane_ok && lane_rx[v] && (!full[v] || pull[v]);
            drop        = drop | (rx && lane_ok && lane_rx[v] && full[v] && !pull[v]);
            credit_o[v] = !full[v] || pull[v] || !reset;
        end
    end

    assign overflow = drop && reset;
    assign pull_sel = |pull;
    assign head     = mem_q[vc_sel_q][rd_ptr_q[vc_sel_q]];

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= data_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + PW'(1);
                end
                if (pull[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PW'(1);
                end
                case ({push[v], pull[v]})
                    2'b10:   count_q[v] <= count_q[v] + CW'(1);
                    2'b01:   count_q[v] <= count_q[v] - CW'(1);
                    default: count_q[v] <= count_q[v];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first non-empty VC at or after rr_ptr, wrapping
    // ------------------------------------------------------------------
    always_comb begin
        found    = 1'b0;
        vc_next  = rr_ptr_q;
        cand_sum = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + VW1'(i);
            if (cand_sum >= VW1'(NUM_VC)) begin
                cand_sum = cand_sum - VW1'(NUM_VC);
            end
            if (!found && nonempty[cand_sum[VW-1:0]]) begin
                found   = 1'b1;
                vc_next = cand_sum[VW-1:0];
            end
        end
    end

    // Packet ends on the last payload pull, or on the size pull when S = 0.
    assign pkt_end = pull_sel &&
                     (((fidx_q == F_SIZE) && (head == '0)) ||
                      ((fidx_q == F_PAY)  && (rem_q == TAM_FLIT'(1))));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|nonempty) state_d = S_REQ;
            S_REQ:   if (ack_h)     state_d = S_SEND;
            S_SEND:  if (pkt_end)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (forced inactive while reset is held)
    always_comb begin
        h       = (state_q == S_REQ)  && reset;
        sender  = (state_q == S_SEND) && reset;
        data_av = (state_q == S_SEND) && nonempty[vc_sel_q] && reset;
        data    = head;
        vc_sel  = vc_sel_q;
    end

    // ------------------------------------------------------------------
    // VC selection, round-robin pointer and packet framing counters
    // ------------------------------------------------------------------
    always_comb begin
        vc_sel_d = vc_sel_q;
        rr_ptr_d = rr_ptr_q;
        fidx_d   = fidx_q;
        rem_d    = rem_q;
        if ((state_q == S_IDLE) && (|nonempty)) begin
            vc_sel_d = vc_next;
        end
        if (pkt_end) begin
            rr_ptr_d = (vc_sel_q == VW'(NUM_VC - 1)) ? '0 : vc_sel_q + VW'(1);
            fidx_d   = F_HDR;
            rem_d    = '0;
        end else if (pull_sel) begin
            case (fidx_q)
                F_HDR:   fidx_d = F_SIZE;
                F_SIZE: begin
                    fidx_d = F_PAY;
                    rem_d  = head;
                end
                default: rem_d = rem_q - TAM_FLIT'(1);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vc_sel_q <= '0;
            rr_ptr_q <= '0;
            fidx_q   <= F_HDR;
            rem_q    <= '0;
        end else begin
            vc_sel_q <= vc_sel_d;
            rr_ptr_q <= rr_ptr_d;
            fidx_q   <= fidx_d;
            rem_q    <= rem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phoenix_vc_buffer
//  Description : Directed self-checking bench for phoenix_vc_buffer with
//                default parameters (16-bit flits, depth 8, two VCs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phoenix_vc_buffer;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [1:0]  lane_rx;
    logic [15:0] data_in;
    logic [1:0]  credit_o;
    logic        h;
    logic        ack_h;
    logic        data_av;
    logic        data_ack;
    logic [15:0] data;
    logic [0:0]  vc_sel;
    logic        sender;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    phoenix_vc_buffer #(
        .TAM_FLIT   (16),
        .TAM_BUFFER (8),
        .NUM_VC     (2)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .lane_rx  (lane_rx),
        .data_in  (data_in),
        .credit_o (credit_o),
        .h        (h),
        .ack_h    (ack_h),
        .data_av  (data_av),
        .data_ack (data_ack),
        .data     (data),
        .vc_sel   (vc_sel),
        .sender   (sender),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change right after the falling edge; #1 lets combinational outputs settle.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [1:0] lane, input logic [15:0] d);
        rx      = 1'b1;
        lane_rx = lane;
        data_in = d;
        tick();
        rx      = 1'b0;
        lane_rx = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_h();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (h) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("h_within_bound", 32'(seen), 32'd1);
    endtask

    task automatic grant();
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
    endtask

    // Stream a packet with data_ack held high and compare every flit.
    task automatic drain(input logic [15:0] exp [], input logic [0:0] exp_vc);
        data_ack = 1'b1;
        for (int i = 0; i < exp.size(); i++) begin
            settle();
            check_eq($sformatf("drain_av[%0d]", i), 32'(data_av), 32'd1);
            check_eq($sformatf("drain_data[%0d]", i), 32'(data), 32'(exp[i]));
            check_eq($sformatf("drain_vc[%0d]", i), 32'(vc_sel), 32'(exp_vc));
            tick();
        end
        settle();
        check_eq("drain_sender_low", 32'(sender), 32'd0);
        check_eq("drain_av_low", 32'(data_av), 32'd0);
        data_ack = 1'b0;
    endtask

    initial begin
        logic [15:0] p [];
        reset    = 1'b0;
        rx       = 1'b0;
        lane_rx  = 2'b00;
        data_in  = '0;
        ack_h    = 1'b0;
        data_ack = 1'b0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        settle();
        check_eq("rst_credit", 32'(credit_o), 32'h3);
        check_eq("rst_h", 32'(h), 32'd0);
        check_eq("rst_data_av", 32'(data_av), 32'd0);
        check_eq("rst_sender", 32'(sender), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_vc_sel", 32'(vc_sel), 32'd0);
        reset = 1'b1;
        tick();

        // ---------------- Basic packet on VC0 ----------------
        push(2'b01, 16'h0001);
        settle();
        check_eq("t1_h_one_cycle", 32'(h), 32'd0);
        push(2'b01, 16'h0002);
        settle();
        check_eq("t1_h_two_cycles", 32'(h), 32'd1);
        check_eq("t1_req_data_av", 32'(data_av), 32'd0);
        push(2'b01, 16'hAAAA);
        push(2'b01, 16'hBBBB);
        grant();
        settle();
        check_eq("t1_sender", 32'(sender), 32'd1);
        p = '{16'h0001, 16'h0002, 16'hAAAA, 16'hBBBB};
        drain(p, 1'b0);

        // ---------------- Zero-size packet on VC1 ----------------
        push(2'b10, 16'h0005);
        push(2'b10, 16'h0000);
        wait_h();
        check_eq("t2_vc_sel", 32'(vc_sel), 32'd1);
        grant();
        p = '{16'h0005, 16'h0000};
        drain(p, 1'b1);

        // ---------------- Non-one-hot lane is ignored ----------------
        do_reset();
        push(2'b11, 16'h1111);
        push(2'b00, 16'h2222);
        tick();
        tick();
        settle();
        check_eq("t3_badlane_h", 32'(h), 32'd0);
        check_eq("t3_badlane_credit", 32'(credit_o), 32'h3);

        // ---------------- Fill, overflow, push+pull while full ----------------
        push(2'b01, 16'h0010);
        push(2'b01, 16'h0006);
        for (int i = 0; i < 6; i++) push(2'b01, 16'h0100 + 16'(i));
        settle();
        check_eq("t3_full_credit", 32'(credit_o), 32'h2);
        rx = 1'b1; lane_rx = 2'b01; data_in = 16'hDEAD;
        settle();
        check_eq("t3_overflow_pulse", 32'(overflow), 32'd1);
        tick();
        rx = 1'b0; lane_rx = 2'b00;
        settle();
        check_eq("t3_overflow_drop", 32'(overflow), 32'd0);
        check_eq("t3_still_full", 32'(credit_o), 32'h2);
        grant();
        data_ack = 1'b1;
        rx = 1'b1; lane_rx = 2'b01; data_in = 16'h0020;
        settle();
        check_eq("t3_pushpull_credit", 32'(credit_o), 32'h3);
        check_eq("t3_pushpull_noovf", 32'(overflow), 32'd0);
        check_eq("t3_pushpull_head", 32'(data), 32'h0010);
        tick();
        rx = 1'b0; lane_rx = 2'b00; data_ack = 1'b0;
        settle();
        check_eq("t3_refilled", 32'(credit_o), 32'h2);
        check_eq("t3_next_head", 32'(data), 32'h0006);

        // ---------------- Round-robin between VCs ----------------
        do_reset();
        push(2'b01, 16'h0A00); push(2'b01, 16'h0001); push(2'b01, 16'h0A01);
        push(2'b10, 16'h0B00); push(2'b10, 16'h0001); push(2'b10, 16'h0B01);
        push(2'b01, 16'h0C00); push(2'b01, 16'h0000);
        wait_h();
        check_eq("t4_first_vc", 32'(vc_sel), 32'd0);
        grant();
        p = '{16'h0A00, 16'h0001, 16'h0A01};
        drain(p, 1'b0);
        wait_h();
        check_eq("t4_second_vc", 32'(vc_sel), 32'd1);
        grant();
        p = '{16'h0B00, 16'h0001, 16'h0B01};
        drain(p, 1'b1);
        wait_h();
        check_eq("t4_third_vc", 32'(vc_sel), 32'd0);
        grant();
        p = '{16'h0C00, 16'h0000};
        drain(p, 1'b0);

        // ---------------- Back-pressure holds the head ----------------
        do_reset();
        push(2'b01, 16'h0001); push(2'b01, 16'h0001); push(2'b01, 16'h1234);
        wait_h();
        grant();
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq($sformatf("t5_hold_av[%0d]", i), 32'(data_av), 32'd1);
            check_eq($sformatf("t5_hold_data[%0d]", i), 32'(data), 32'h0001);
            tick();
        end
        p = '{16'h0001, 16'h0001, 16'h1234};
        drain(p, 1'b0);

        // ---------------- Reset mid-packet ----------------
        do_reset();
        push(2'b01, 16'h0007); push(2'b01, 16'h0002);
        push(2'b01, 16'h0111); push(2'b01, 16'h0222);
        wait_h();
        grant();
        data_ack = 1'b1;
        settle();
        check_eq("t6_flit0", 32'(data), 32'h0007);
        tick();
        settle();
        check_eq("t6_flit1", 32'(data), 32'h0002);
        tick();
        reset = 1'b0; data_ack = 1'b0;
        settle();
        check_eq("t6_during_rst_av", 32'(data_av), 32'd0);
        check_eq("t6_during_rst_credit", 32'(credit_o), 32'h3);
        tick();
        reset = 1'b1;
        settle();
        check_eq("t6_after_rst_sender", 32'(sender), 32'd0);
        check_eq("t6_after_rst_h", 32'(h), 32'd0);
        check_eq("t6_after_rst_av", 32'(data_av), 32'd0);
        check_eq("t6_after_rst_credit", 32'(credit_o), 32'h3);
        tick(); tick(); tick();
        settle();
        check_eq("t6_discarded_h", 32'(h), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phoenix_vc_buffer.md
PHOENIX_VC_BUFFER -- requirements
Module: phoenix_vc_buffer

Interface
REQ-001 Parameter TAM_FLIT, default 16, flit width in bits (>=4).
REQ-002 Parameter TAM_BUFFER, default 8, per-VC FIFO depth in flits (power of 2, >=2).
REQ-003 Parameter NUM_VC, default 2, number of virtual channels (>=2); VW = clog2(NUM_VC).
REQ-004 clock  in  1  single clock for all logic (no separate receive clock).
REQ-005 reset  in  1  synchronous, active-low reset, sampled on rising clock.
REQ-006 rx  in  1  flit valid from upstream.
REQ-007 lane_rx  in  NUM_VC  one-hot VC select for the incoming flit.
REQ-008 data_in  in  TAM_FLIT  incoming flit.
REQ-009 credit_o  out  NUM_VC  per-VC credit to upstream.
REQ-010 h  out  1  routing request for the selected VC's header.
REQ-011 ack_h  in  1  routing granted.
REQ-012 data_av  out  1  flit available on data.
REQ-013 data_ack  in  1  downstream consumed the flit on data.
REQ-014 data  out  TAM_FLIT  head flit of the selected VC.
REQ-015 vc_sel  out  VW  index of the VC currently selected.
REQ-016 sender  out  1  high while in SEND.
REQ-017 overflow  out  1  one-cycle pulse when a flit is dropped.

Function
REQ-018 One circular FIFO per VC with an occupancy counter of clog2(TAM_BUFFER)+1 bits; read and write pointers wrap modulo TAM_BUFFER.
REQ-019 Push to VC v on a rising edge when rx=1 and lane_rx[v]=1; the flit is visible at the head and in the count from the next cycle.
REQ-020 rx=1 with lane_rx not one-hot (zero or multiple bits set) is ignored; no FIFO changes.
REQ-021 credit_o[v] = (count_v != TAM_BUFFER) OR (pull of v this cycle).
REQ-022 Push to a full VC without a same-cycle pull drops the flit and pulses overflow for one cycle; a full VC with a same-cycle push and pull stores the flit.
REQ-023 Shared FSM states: IDLE, REQ, SEND.
REQ-024 IDLE: if any VC is non-empty, latch vc_sel = first non-empty VC at or after rr_ptr (round-robin, wrapping), then go to REQ; otherwise remain in IDLE.
REQ-025 REQ: h = 1, data_av = 0; on ack_h=1 go to SEND at the next edge. vc_sel is held.
REQ-026 SEND: sender = 1; data_av = (count_vc_sel != 0); pull = data_av AND data_ack; data = head of vc_sel.
REQ-027 Flit framing: flit 0 = header, flit 1 = payload size S (low TAM_FLIT bits, unsigned), followed by S payload flits.
REQ-028 A flit index and a remaining-payload counter advance only on a pull; when flit 1 is pulled, the counter loads S.
REQ-029 The packet ends on the pull of the last payload flit, or on the pull of flit 1 when S = 0; at that edge go to IDLE and set rr_ptr = vc_sel + 1 mod NUM_VC.
REQ-030 Outside SEND, h = 0 except in REQ, data_av = 0, and pull = 0; data shows the head of vc_sel in all states.
REQ-031 A VC's FIFO running empty mid-packet stalls SEND (data_av = 0) with no timeout; pushes to other VCs continue.
REQ-032 A packet is never interleaved with another VC's flits on data.

Reset
REQ-033 reset=0 at an edge: all FIFOs empty, pointers 0, FSM IDLE, rr_ptr 0, vc_sel 0, flit counters 0.
REQ-034 Outputs during and after reset: credit_o all 1, h=0, data_av=0, sender=0, overflow=0.
REQ-035 Reset asserted mid-packet aborts the packet; flits in flight are discarded.

Verification
REQ-036 Defaults: push VC0 flits 0x0001, 0x0002, 0xAAAA, 0xBBBB -> h=1 two cycles after the first push; ack_h -> data_av with data 0x0001, 0x0002, 0xAAAA, 0xBBBB in order under data_ack=1; IDLE after 0xBBBB.
REQ-037 Packet with size 0 (0x0005, 0x0000) on VC1 -> the packet ends after two pulls; sender falls the cycle after.
REQ-038 Fill VC0 with 8 flits, no data_ack -> credit_o[0]=0, credit_o[1]=1; ninth push -> overflow pulse, count stays 8; push+pull while full -> no overflow.
REQ-039 VC0 and VC1 both hold packets at rr_ptr=0 -> VC0 served first and then VC1, with vc_sel 0 then 1 and no interleaving; next VC0 packet served after VC1.
REQ-040 reset=0 in SEND after 2 of 4 flits -> the next cycle is IDLE, h=0, data_av=0, and credit_o is all 1.
REQ-041 data_ack withheld for 5 cycles in SEND -> data holds stable with data_av=1 and no pointer movement.
